instr_mem_ctrl: RTL and testbench

Program-side counterpart of the 8-bit processor's fetch path. It holds a 256x8 instruction memory and answers the processor's fetch address with the instruction byte. A byte-stream loader with a valid/ready handshake writes programs into the memory, and a clear engine fills it with a constant. The block gates the processor through `cpu_run` so that no fetch ever sees a partly written program.

---
 rtl/imc_pkg.sv | 13 +
 rtl/imem_array.sv | 25 ++
 rtl/instr_mem_ctrl.sv | 139 +++++++++++++
 tb/tb_instr_mem_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imc_pkg.sv
// rtl/imc_pkg.sv - shared types and defaults for the instruction memory controller
package imc_pkg;

  localparam int IMC_ADDR_W = 8;
  localparam int IMC_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    CLEAR = 2'd2
  } imcState_t;

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - instruction storage, one synchronous write port, one async read port
// Contents are deliberately not reset so a program survives a controller reset.
module imem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/instr_mem_ctrl.sv
// rtl/instr_mem_ctrl.sv - fetch port, byte-stream loader and clear engine for the program memory
// The processor only runs from IDLE after a complete load, so it never fetches a partial program.
module instr_mem_ctrl
  import imc_pkg::*;
#(
  parameter int                ADDR_W = IMC_ADDR_W,
  parameter int                DATA_W = IMC_DATA_W,
  parameter logic [DATA_W-1:0] FILL   = '0
) (
  input  logic              CLK,
  input  logic              CLB,
  input  logic [ADDR_W-1:0] FromCPU_addr,
  output logic [DATA_W-1:0] ToCPU_instr,
  output logic              cpu_run,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W-1:0] ld_count,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              clr_start,
  output logic              done,
  output logic              busy,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_TOP  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   REM_FULL = {1'b1, {ADDR_W{1'b0}}};

  imcState_t         state;
  imcState_t         nextState;
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   remaining;
  logic              loaded;
  logic              accept;
  logic              lastAccept;
  logic              clearLast;
  logic              wrEn;
  logic [DATA_W-1:0] wrData;
  logic [DATA_W-1:0] rdData;

  assign accept     = (state == LOAD) && ld_valid;
  assign lastAccept = accept && (remaining == REM_ONE);
  assign clearLast  = (state == CLEAR) && (ptr == PTR_TOP);

  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE: begin
        if (clr_start) begin
          nextState = CLEAR;
        end else if (ld_start) begin
          nextState = LOAD;
        end
      end
      LOAD: begin
        if (lastAccept) begin
          nextState = IDLE;
        end
      end
      CLEAR: begin
        if (clearLast) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    ld_ready    = (state == LOAD);
    busy        = (state != IDLE);
    cpu_run     = (state == IDLE) && loaded;
    ToCPU_instr = (state == IDLE) ? rdData : FILL;
    wrEn        = accept || (state == CLEAR);
    wrData      = (state == LOAD) ? ld_data : FILL;
  end

  // Pointer, byte budget and checksum; a zero count means a full-memory load.
  always_ff @(posedge CLK or posedge CLB) begin
    if (CLB) begin
      ptr       <= '0;
      remaining <= '0;
      checksum  <= '0;
      done      <= 1'b0;
      loaded    <= 1'b0;
    end else begin
      done <= lastAccept || clearLast;
      case (state)
        IDLE: begin
          if (clr_start) begin
            ptr <= '0;
          end else if (ld_start) begin
            ptr       <= ld_base;
            remaining <= (ld_count == '0) ? REM_FULL : {1'b0, ld_count};
            checksum  <= '0;
          end
        end
        LOAD: begin
          if (accept) begin
            ptr       <= ptr + PTR_ONE;
            remaining <= remaining - REM_ONE;
            checksum  <= checksum + ld_data;
            if (lastAccept) begin
              loaded <= 1'b1;
            end
          end
        end
        CLEAR: begin
          ptr <= ptr + PTR_ONE;
        end
        default: ;
      endcase
    end
  end

  imem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) uArray (
    .clk   (CLK),
    .wrEn  (wrEn),
    .wrAddr(ptr),
    .wrData(wrData),
    .rdAddr(FromCPU_addr),
    .rdData(rdData)
  );

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb/tb_instr_mem_ctrl.sv - scoreboard bench for instr_mem_ctrl with a behavioural memory model
module tb_instr_mem_ctrl;

  logic       CLK = 1'b0;
  logic       CLB;
  logic [7:0] FromCPU_addr;
  logic [7:0] ToCPU_instr;
  logic       cpu_run;
  logic       ld_start;
  logic [7:0] ld_base;
  logic [7:0] ld_count;
  logic       ld_valid;
  logic       ld_ready;
  logic [7:0] ld_data;
  logic       clr_start;
  logic       done;
  logic       busy;
  logic [7:0] checksum;

  instr_mem_ctrl dut (
    .CLK         (CLK),
    .CLB         (CLB),
    .FromCPU_addr(FromCPU_addr),
    .ToCPU_instr (ToCPU_instr),
    .cpu_run     (cpu_run),
    .ld_start    (ld_start),
    .ld_base     (ld_base),
    .ld_count    (ld_count),
    .ld_valid    (ld_valid),
    .ld_ready    (ld_ready),
    .ld_data     (ld_data),
    .clr_start   (clr_start),
    .done        (done),
    .busy        (busy),
    .checksum    (checksum)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [7:0] sum;
    logic       run;
  } doneExp_t;

  int         nVec  = 0;
  int         nMiss = 0;
  logic [7:0] refMem [256];
  logic       refLoaded;
  logic [7:0] refChecksum;
  doneExp_t   doneQ[$];
  logic [7:0] fetchQ[$];
  logic [7:0] pat[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMiss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse and every posted fetch is matched against the scoreboard.
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      if (doneQ.size() == 0) begin
        check("unexpected_done", 32'(done), 32'd0);
      end else begin
        doneExp_t e;
        e = doneQ.pop_front();
        check("done_checksum", 32'(checksum), 32'(e.sum));
        check("done_cpu_run", 32'(cpu_run), 32'(e.run));
        check("done_busy", 32'(busy), 32'd0);
      end
    end
    if (fetchQ.size() > 0) begin
      logic [7:0] f;
      f = fetchQ.pop_front();
      check("fetch_data", 32'(ToCPU_instr), 32'(f));
    end
  end

  task automatic fetch(input logic [7:0] a);
    FromCPU_addr = a;
    fetchQ.push_back(refMem[a]);
    @(posedge CLK);
    #1;
  endtask

  task automatic doLoad(input logic [7:0] base, input logic [7:0] count,
                        input int stallMode, input int abortAfter);
    int         n;
    int         accepted;
    int         cyc;
    logic [7:0] sum;
    logic [7:0] bytes[$];
    logic       v;
    logic       rdy;
    bit         aborted;
    n = (count == 8'd0) ? 256 : int'(count);
    for (int i = 0; i < n; i++) begin
      bytes.push_back((i < pat.size()) ? pat[i] : 8'($urandom));
    end
    pat.delete();
    ld_base  = base;
    ld_count = count;
    ld_start = 1'b1;
    @(posedge CLK);
    #1;
    ld_start = 1'b0;
    accepted = 0;
    cyc      = 0;
    sum      = 8'd0;
    aborted  = 1'b0;
    while (accepted < n && cyc < 3000) begin
      if (abortAfter > 0 && accepted == abortAfter) begin
        aborted = 1'b1;
        break;
      end
      case (stallMode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      ld_valid = v;
      ld_data  = bytes[accepted];
      rdy      = ld_ready;
      check("ld_ready_active", 32'(rdy), 32'd1);
      check("checksum_running", 32'(checksum), 32'(sum));
      check("busy_load", 32'(busy), 32'd1);
      @(posedge CLK);
      if (v && rdy) begin
        refMem[base + 8'(accepted)] = bytes[accepted];
        sum = sum + bytes[accepted];
        accepted++;
      end
      cyc++;
      #1;
    end
    ld_valid = 1'b0;
    if (aborted) begin
      CLB = 1'b1;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_ld_ready", 32'(ld_ready), 32'd0);
      check("abort_cpu_run", 32'(cpu_run), 32'd0);
      check("abort_checksum", 32'(checksum), 32'd0);
      refLoaded   = 1'b0;
      refChecksum = 8'd0;
      @(posedge CLK);
      #1;
      CLB = 1'b0;
    end else begin
      check("load_accepts", 32'(accepted), 32'(n));
      refLoaded   = 1'b1;
      refChecksum = sum;
      doneQ.push_back('{sum: sum, run: 1'b1});
      ld_valid = 1'b1;
      check("ld_ready_after_last", 32'(ld_ready), 32'd0);
      @(posedge CLK);
      #1;
      ld_valid = 1'b0;
    end
  endtask

  task automatic doClear();
    int n;
    int cyc;
    clr_start = 1'b1;
    ld_start  = 1'b1;
    ld_base   = 8'($urandom);
    ld_count  = 8'd5;
    doneQ.push_back('{sum: refChecksum, run: refLoaded});
    @(posedge CLK);
    #1;
    clr_start = 1'b0;
    ld_start  = 1'b0;
    n   = 0;
    cyc = 0;
    while (busy && cyc < 400) begin
      n++;
      check("clear_ld_ready", 32'(ld_ready), 32'd0);
      FromCPU_addr = 8'($urandom);
      fetchQ.push_back(8'h00);
      ld_start  = 1'($urandom_range(0, 1));
      clr_start = 1'($urandom_range(0, 1));
      @(posedge CLK);
      #1;
      cyc++;
    end
    ld_start  = 1'b0;
    clr_start = 1'b0;
    check("clear_busy_cycles", 32'(n), 32'd256);
    for (int a = 0; a < 256; a++) refMem[a] = 8'h00;
  endtask

  initial begin
    CLB          = 1'b1;
    FromCPU_addr = 8'd0;
    ld_start     = 1'b0;
    ld_base      = 8'd0;
    ld_count     = 8'd0;
    ld_valid     = 1'b0;
    ld_data      = 8'd0;
    clr_start    = 1'b0;
    refLoaded    = 1'b0;
    refChecksum  = 8'd0;
    repeat (3) @(posedge CLK);
    #1;
    CLB = 1'b0;
    @(posedge CLK);
    #1;

    check("reset_cpu_run", 32'(cpu_run), 32'd0);
    check("reset_ld_ready", 32'(ld_ready), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_checksum", 32'(checksum), 32'd0);

    pat = '{8'h12, 8'h34, 8'h56, 8'h78};
    doLoad(8'h00, 8'd4, 0, 0);
    check("basic_checksum_value", 32'(refChecksum), 32'h14);
    fetch(8'h02);
    check("cpu_run_after_load", 32'(cpu_run), 32'd1);

    pat = '{8'hA1, 8'hB2, 8'hC3};
    doLoad(8'hFE, 8'd3, 1, 0);
    fetch(8'hFE);
    fetch(8'hFF);
    fetch(8'h00);

    doClear();
    for (int a = 0; a < 256; a++) fetch(8'(a));
    check("cpu_run_after_clear", 32'(cpu_run), 32'd1);

    doLoad(8'h40, 8'd5, 0, 2);
    fetch(8'h40);
    fetch(8'h41);
    fetch(8'h42);
    check("cpu_run_after_abort", 32'(cpu_run), 32'd0);

    for (int k = 0; k < 4; k++) begin
      doLoad(8'($urandom), 8'($urandom_range(1, 40)), 2, 0);
      check("cpu_run_rand_load", 32'(cpu_run), 32'd1);
    end

    doLoad(8'($urandom), 8'd0, 2, 0);

    for (int k = 0; k < 24; k++) fetch(8'($urandom));

    repeat (3) @(posedge CLK);
    #1;
    check("pending_done", 32'(doneQ.size()), 32'd0);
    check("pending_fetch", 32'(fetchQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
